// File: rtl/body_code_if.sv
// Handshake bundle between a body-type request source and the body code encoder.
// Request side: type_valid/type_in/type_ready. Code side: code_valid/code_out/code_ready.
interface body_code_if;
  logic       type_valid;
  logic       type_in;
  logic       type_ready;
  logic       code_valid;
  logic [2:0] code_out;
  logic       code_ready;

  // Encoder side
  modport slave (
    input  type_valid,
    input  type_in,
    output type_ready,
    output code_valid,
    output code_out,
    input  code_ready
  );

  // Request producer / code consumer side
  modport master (
    output type_valid,
    output type_in,
    input  type_ready,
    input  code_valid,
    input  code_out,
    output code_ready
  );
endinterface

// File: rtl/body_code_encoder.sv
// Body code encoder: turns 1-bit body-type requests into 3-bit body codes.
// Type 1 alternates 000/111; type 0 cycles 001..110. Codes are produced when the
// request is accepted and held in a DEPTH-entry FIFO until the consumer takes them.
// Optional macro BODY_ENC_CHECK_EN enables a sticky self-check (err) that
// reclassifies every pushed code against its requested type; otherwise err is 0.
module body_code_encoder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  body_code_if.slave               bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         sent_cnt,
  output logic                     err
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [2:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic             sel1;
  logic [2:0]       gen0;
  logic [2:0]       enc_code;
  logic             push;
  logic             pop;

  // Handshake qualification; type_ready deliberately ignores code_ready
  always_comb begin
    bus.type_ready = rst_n & (level_q != LVL_W'(DEPTH));
    bus.code_valid = (level_q != '0);
    push           = bus.type_valid & bus.type_ready;
    pop            = bus.code_valid & bus.code_ready;
    bus.code_out   = bus.code_valid ? mem[rd_ptr] : '0;
    level          = level_q;
  end

  // Code selection for the request currently offered
  always_comb begin
    enc_code = gen0;
    if (bus.type_in) begin
      enc_code = sel1 ? 3'b111 : 3'b000;
    end
  end

  // FIFO storage; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= enc_code;
    end
  end

  // Pointers, occupancy and per-type sequence state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      sel1    <= 1'b0;
      gen0    <= 3'b001;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (bus.type_in) begin
          sel1 <= ~sel1;
        end else begin
          gen0 <= (gen0 == 3'b110) ? 3'b001 : gen0 + 3'd1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        level_q <= level_q + 1'b1;
      end else if (pop && !push) begin
        level_q <= level_q - 1'b1;
      end
    end
  end

  // Saturating count of delivered codes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sent_cnt <= '0;
    end else if (pop && (sent_cnt != '1)) begin
      sent_cnt <= sent_cnt + 1'b1;
    end
  end

`ifdef BODY_ENC_CHECK_EN
  logic code_class;

  // Reclassify the code being pushed the same way the downstream classifier does
  always_comb begin
    code_class = (enc_code == 3'b000) | (enc_code == 3'b111);
  end

  // Sticky error on any class disagreement
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (push && (code_class != bus.type_in)) begin
      err <= 1'b1;
    end
  end
`else
  // Checker absent
  always_comb begin
    err = 1'b0;
  end
`endif

endmodule

// File: tb/tb_body_code_encoder.sv
// Directed bench for body_code_encoder: a reference queue model checks the
// outputs every cycle, and directed tests compare the delivered code stream
// against hand-computed sequences.
module tb_body_code_encoder;
  localparam int unsigned DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic [2:0] level;
  logic [7:0] sent_cnt;
  logic       err;

  body_code_if bus ();

  body_code_encoder #(.DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .level    (level),
    .sent_cnt (sent_cnt),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // reference model
  logic [2:0] m_q [$];
  logic       m_sel1;
  logic [2:0] m_gen0;
  int         m_sent;

  // codes observed on code_out at each pop, and the expected sequence
  logic [2:0] dut_log [$];
  logic [2:0] exp_log [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_sel1 = 1'b0;
    m_gen0 = 3'b001;
    m_sent = 0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance
  task automatic cycle(input bit tv, input bit ti, input bit cr);
    bit push;
    bit pop;
    logic [2:0] code;
    bus.type_valid = tv;
    bus.type_in    = ti;
    bus.code_ready = cr;
    #1;
    check("level",      32'(level),          32'(m_q.size()));
    check("code_valid", 32'(bus.code_valid), 32'(m_q.size() != 0));
    check("code_out",   32'(bus.code_out),   (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
    check("type_ready", 32'(bus.type_ready), 32'(m_q.size() != DEPTH));
    check("sent_cnt",   32'(sent_cnt),       32'(m_sent));
    check("err",        32'(err),            32'd0);
    push = tv && (m_q.size() != DEPTH);
    pop  = cr && (m_q.size() != 0);
    if (pop) begin
      dut_log.push_back(bus.code_out);
      void'(m_q.pop_front());
      if (m_sent < 255) m_sent++;
    end
    if (push) begin
      if (ti) begin
        code   = m_sel1 ? 3'b111 : 3'b000;
        m_sel1 = ~m_sel1;
      end else begin
        code   = m_gen0;
        m_gen0 = (m_gen0 == 3'd6) ? 3'd1 : m_gen0 + 3'd1;
      end
      m_q.push_back(code);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.type_valid = 1'b0;
    bus.type_in    = 1'b0;
    bus.code_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_type_ready", 32'(bus.type_ready), 32'd0);
    @(posedge clk);
    #1;
    check("rst_level",      32'(level),          32'd0);
    check("rst_code_valid", 32'(bus.code_valid), 32'd0);
    check("rst_code_out",   32'(bus.code_out),   32'd0);
    check("rst_sent_cnt",   32'(sent_cnt),       32'd0);
    check("rst_err",        32'(err),            32'd0);
    check("rst_type_ready2", 32'(bus.type_ready), 32'd0);
    rst_n = 1'b1;
    model_clear();
    dut_log.delete();
  endtask

  task automatic check_log(input string tag);
    check({tag, "_count"}, 32'(dut_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size(); i++) begin
      check($sformatf("%s_%0d", tag, i),
            (i < dut_log.size()) ? 32'(dut_log[i]) : 32'hxxxx_xxxx,
            32'(exp_log[i]));
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b1;
    bus.type_valid = 1'b0;
    bus.type_in    = 1'b0;
    bus.code_ready = 1'b0;
    model_clear();
    @(posedge clk);
    #1;

    // Test 1: type 1 alternates 000/111
    do_reset();
    repeat (3) cycle(1, 1, 1);
    repeat (3) cycle(0, 0, 1);
    exp_log = '{3'b000, 3'b111, 3'b000};
    check_log("t1");
    check("t1_sent", 32'(sent_cnt), 32'd3);

    // Test 2: type 0 cycles 001..110 and wraps
    do_reset();
    repeat (7) cycle(1, 0, 1);
    repeat (3) cycle(0, 0, 1);
    exp_log = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1};
    check_log("t2");

    // Test 3: full FIFO back-pressure, then one pop frees a slot
    do_reset();
    repeat (DEPTH) cycle(1, 0, 0);
    check("t3_level_full", 32'(level), 32'd4);
    check("t3_ready_full", 32'(bus.type_ready), 32'd0);
    cycle(1, 1, 0);
    check("t3_level_held", 32'(level), 32'd4);
    cycle(1, 1, 1);
    check("t3_level_after_pop", 32'(level), 32'd3);
    check("t3_ready_after_pop", 32'(bus.type_ready), 32'd1);
    repeat (6) cycle(0, 0, 1);
    exp_log = '{3'd1, 3'd2, 3'd3, 3'd4};
    check_log("t3");

    // Test 4: interleaved types, simultaneous push+pop at level 2
    do_reset();
    cycle(1, 1, 0);
    cycle(1, 0, 0);
    check("t4_level2", 32'(level), 32'd2);
    cycle(1, 1, 1);
    check("t4_level_pp1", 32'(level), 32'd2);
    cycle(1, 0, 1);
    check("t4_level_pp2", 32'(level), 32'd2);
    repeat (3) cycle(0, 0, 1);
    exp_log = '{3'b000, 3'b001, 3'b111, 3'b010};
    check_log("t4");

    // Test 5: reset with buffered codes discards them and restarts sequences
    do_reset();
    cycle(1, 1, 0);
    cycle(1, 0, 0);
    cycle(1, 1, 0);
    check("t5_level3", 32'(level), 32'd3);
    do_reset();
    cycle(1, 1, 1);
    cycle(1, 0, 1);
    repeat (2) cycle(0, 0, 1);
    exp_log = '{3'b000, 3'b001};
    check_log("t5");

    // Test 6: random traffic, then saturation of sent_cnt
    do_reset();
    for (int unsigned i = 0; i < 1000; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    repeat (600) cycle(1, 1'($urandom_range(0, 1)), 1);
    check("t6_sent_sat", 32'(sent_cnt), 32'd255);
    check("t6_err", 32'(err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time bound
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule
